// File: rtl/fft_butterfly_pipe.sv
// fft_butterfly_pipe
//   Streaming radix-2 DIT complex butterfly, three register stages:
//     S1: four partial products of B*W, plus A / scale / valid
//     S2: complex product P = W*B, rounded half-up back to integer scale
//     S3: Y = A + P, Z = A - P, optional /2, saturation to WIDTH bits
//   One operand set per cycle; a single global advance enable stalls
//   every stage together when the output is held.
//
// Ports
//   Clock, nReset         clock (rising edge), async active-low reset
//   in_valid / in_ready   operand handshake (in_ready = !out_valid || out_ready)
//   a_*, b_*              WIDTH-bit signed operands A and B
//   w_*                   TW-bit signed Q1.(TW-1) twiddle W
//   scale                 halve results; travels with its operand set
//   out_valid / out_ready result handshake
//   y_*, z_*              WIDTH-bit signed results Y and Z
//   sat_flag              sticky: a valid result clipped since last clear
//   clear                 synchronous clear of sat_flag and count
//   count                 accepted result sets, wraps at 2^CNT_W
module fft_butterfly_pipe #(
  parameter int WIDTH = 8,
  parameter int TW    = 8,
  parameter int CNT_W = 16
) (
  input  logic              Clock,
  input  logic              nReset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  a_re,
  input  logic [WIDTH-1:0]  a_im,
  input  logic [WIDTH-1:0]  b_re,
  input  logic [WIDTH-1:0]  b_im,
  input  logic [TW-1:0]     w_re,
  input  logic [TW-1:0]     w_im,
  input  logic              scale,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  y_re,
  output logic [WIDTH-1:0]  y_im,
  output logic [WIDTH-1:0]  z_re,
  output logic [WIDTH-1:0]  z_im,
  output logic              sat_flag,
  input  logic              clear,
  output logic [CNT_W-1:0]  count
);
  localparam int PW = WIDTH + TW;   // product width
  localparam int RW = WIDTH + 2;    // rounded product width
  localparam int SW = WIDTH + 3;    // sum/difference width

  // Half an LSB of the Q1.(TW-1) result, for round-half-up.
  localparam logic signed [PW:0] RND = {{(PW-TW+2){1'b0}}, 1'b1, {(TW-2){1'b0}}};

  // Returns {clipped, saturated value}. The value fits when all bits from
  // the sign bit of the WIDTH-bit result upward agree.
  function automatic logic [WIDTH:0] sat_fn(input logic [SW-1:0] v);
    if ((&v[SW-1:WIDTH-1]) || !(|v[SW-1:WIDTH-1]))
      sat_fn = {1'b0, v[WIDTH-1:0]};
    else if (v[SW-1])
      sat_fn = {1'b1, 1'b1, {(WIDTH-1){1'b0}}};
    else
      sat_fn = {1'b1, 1'b0, {(WIDTH-1){1'b1}}};
  endfunction

  // Stage registers
  logic                    v1_q, v1_d, s1_q, s1_d;
  logic signed [WIDTH-1:0] a1_re_q, a1_re_d, a1_im_q, a1_im_d;
  logic signed [PW-1:0]    rr_q, rr_d, ii_q, ii_d, ri_q, ri_d, ir_q, ir_d;
  logic                    v2_q, v2_d, s2_q, s2_d;
  logic signed [WIDTH-1:0] a2_re_q, a2_re_d, a2_im_q, a2_im_d;
  logic signed [RW-1:0]    p2_re_q, p2_re_d, p2_im_q, p2_im_d;
  logic                    out_valid_q, out_valid_d;
  logic [WIDTH-1:0]        y_re_q, y_re_d, y_im_q, y_im_d;
  logic [WIDTH-1:0]        z_re_q, z_re_d, z_im_q, z_im_d;
  logic                    sat_q, sat_d;
  logic [CNT_W-1:0]        count_q, count_d;

  // Combinational intermediates
  logic                    adv;
  logic signed [PW-1:0]    b_re_x, b_im_x, w_re_x, w_im_x;
  logic signed [PW:0]      p_re_full, p_im_full, p_re_sh, p_im_sh;
  logic signed [SW-1:0]    y_re_w, y_im_w, z_re_w, z_im_w;
  logic signed [SW-1:0]    y_re_s, y_im_s, z_re_s, z_im_s;
  logic [WIDTH:0]          y_re_r, y_im_r, z_re_r, z_im_r;
  logic                    clip_any;
  logic                    unused_bits;

  always_comb begin
    adv = !out_valid_q || out_ready;

    // S1: sign-extend to full product width so each product is exact.
    b_re_x = {{TW{b_re[WIDTH-1]}}, b_re};
    b_im_x = {{TW{b_im[WIDTH-1]}}, b_im};
    w_re_x = {{WIDTH{w_re[TW-1]}}, w_re};
    w_im_x = {{WIDTH{w_im[TW-1]}}, w_im};

    // S2: complex product, round half up, drop the TW-1 fraction bits.
    p_re_full = {rr_q[PW-1], rr_q} - {ii_q[PW-1], ii_q} + RND;
    p_im_full = {ri_q[PW-1], ri_q} + {ir_q[PW-1], ir_q} + RND;
    p_re_sh   = p_re_full >>> (TW-1);
    p_im_sh   = p_im_full >>> (TW-1);

    // S3: butterfly with one guard bit, optional floor-halving, clip.
    y_re_w = {{3{a2_re_q[WIDTH-1]}}, a2_re_q} + {p2_re_q[RW-1], p2_re_q};
    y_im_w = {{3{a2_im_q[WIDTH-1]}}, a2_im_q} + {p2_im_q[RW-1], p2_im_q};
    z_re_w = {{3{a2_re_q[WIDTH-1]}}, a2_re_q} - {p2_re_q[RW-1], p2_re_q};
    z_im_w = {{3{a2_im_q[WIDTH-1]}}, a2_im_q} - {p2_im_q[RW-1], p2_im_q};
    y_re_s = s2_q ? (y_re_w >>> 1) : y_re_w;
    y_im_s = s2_q ? (y_im_w >>> 1) : y_im_w;
    z_re_s = s2_q ? (z_re_w >>> 1) : z_re_w;
    z_im_s = s2_q ? (z_im_w >>> 1) : z_im_w;
    y_re_r = sat_fn(y_re_s);
    y_im_r = sat_fn(y_im_s);
    z_re_r = sat_fn(z_re_s);
    z_im_r = sat_fn(z_im_s);
    clip_any = y_re_r[WIDTH] | y_im_r[WIDTH] | z_re_r[WIDTH] | z_im_r[WIDTH];

    // Bits discarded by rounding / truncation.
    unused_bits = ^{p_re_sh[PW:RW], p_im_sh[PW:RW]};

    // Defaults: every stage holds.
    v1_d = v1_q;  s1_d = s1_q;  a1_re_d = a1_re_q;  a1_im_d = a1_im_q;
    rr_d = rr_q;  ii_d = ii_q;  ri_d = ri_q;  ir_d = ir_q;
    v2_d = v2_q;  s2_d = s2_q;  a2_re_d = a2_re_q;  a2_im_d = a2_im_q;
    p2_re_d = p2_re_q;  p2_im_d = p2_im_q;
    out_valid_d = out_valid_q;
    y_re_d = y_re_q;  y_im_d = y_im_q;  z_re_d = z_re_q;  z_im_d = z_im_q;
    sat_d = sat_q;
    count_d = count_q;

    if (adv) begin
      v1_d    = in_valid && adv;
      s1_d    = scale;
      a1_re_d = a_re;
      a1_im_d = a_im;
      rr_d    = b_re_x * w_re_x;
      ii_d    = b_im_x * w_im_x;
      ri_d    = b_re_x * w_im_x;
      ir_d    = b_im_x * w_re_x;

      v2_d    = v1_q;
      s2_d    = s1_q;
      a2_re_d = a1_re_q;
      a2_im_d = a1_im_q;
      p2_re_d = p_re_sh[RW-1:0];
      p2_im_d = p_im_sh[RW-1:0];

      // Data registers also load on bubbles; out_valid marks them stale.
      out_valid_d = v2_q;
      y_re_d = y_re_r[WIDTH-1:0];
      y_im_d = y_im_r[WIDTH-1:0];
      z_re_d = z_re_r[WIDTH-1:0];
      z_im_d = z_im_r[WIDTH-1:0];
    end

    // clear takes priority over a same-cycle saturation or acceptance.
    if (clear)
      sat_d = 1'b0;
    else if (adv && v2_q && clip_any)
      sat_d = 1'b1;

    if (clear)
      count_d = '0;
    else if (out_valid_q && out_ready)
      count_d = count_q + CNT_W'(1);
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      v1_q <= 1'b0;  s1_q <= 1'b0;  a1_re_q <= '0;  a1_im_q <= '0;
      rr_q <= '0;  ii_q <= '0;  ri_q <= '0;  ir_q <= '0;
      v2_q <= 1'b0;  s2_q <= 1'b0;  a2_re_q <= '0;  a2_im_q <= '0;
      p2_re_q <= '0;  p2_im_q <= '0;
      out_valid_q <= 1'b0;
      y_re_q <= '0;  y_im_q <= '0;  z_re_q <= '0;  z_im_q <= '0;
      sat_q <= 1'b0;
      count_q <= '0;
    end else begin
      v1_q <= v1_d;  s1_q <= s1_d;  a1_re_q <= a1_re_d;  a1_im_q <= a1_im_d;
      rr_q <= rr_d;  ii_q <= ii_d;  ri_q <= ri_d;  ir_q <= ir_d;
      v2_q <= v2_d;  s2_q <= s2_d;  a2_re_q <= a2_re_d;  a2_im_q <= a2_im_d;
      p2_re_q <= p2_re_d;  p2_im_q <= p2_im_d;
      out_valid_q <= out_valid_d;
      y_re_q <= y_re_d;  y_im_q <= y_im_d;  z_re_q <= z_re_d;  z_im_q <= z_im_d;
      sat_q <= sat_d;
      count_q <= count_d;
    end
  end

  assign in_ready  = adv;
  assign out_valid = out_valid_q;
  assign y_re      = y_re_q;
  assign y_im      = y_im_q;
  assign z_re      = z_re_q;
  assign z_im      = z_im_q;
  assign sat_flag  = sat_q;
  assign count     = count_q;

endmodule
